// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, VALID} fetch_state_t;

  typedef enum logic [1:0] {PcInc, PcTarget, PcTrap} pc_sel_t;

  localparam int unsigned INSTR_WIDTH = 32;
  localparam int unsigned PC_STEP     = 4;
  localparam logic [INSTR_WIDTH-1:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register: sync reset to RESET_PC, load-enable, next-value mux.
module fetch_pc_reg
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0,
  parameter logic [ADDR_WIDTH-1:0] TRAP_VEC = ADDR_WIDTH'(32'h100)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_en_i,
  input  pc_sel_t               sel_i,
  input  logic [ADDR_WIDTH-1:0] target_i,
  output logic [ADDR_WIDTH-1:0] pc_o,
  output logic [ADDR_WIDTH-1:0] pc_next_o
);

  logic [ADDR_WIDTH-1:0] pc_q, pc_d;

  always_comb begin
    pc_d = pc_q;
    if (load_en_i) begin
      unique case (sel_i)
        PcInc:    pc_d = pc_q + ADDR_WIDTH'(PC_STEP);
        PcTarget: pc_d = target_i;
        PcTrap:   pc_d = TRAP_VEC;
        default:  pc_d = pc_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o      = pc_q;
  assign pc_next_o = pc_d;

endmodule

// File: rtl/fetch_sequencer.sv
// Multi-cycle instruction-fetch controller with one outstanding request.
// Optional misaligned-redirect trap enabled by FETCH_MISALIGN_TRAP_EN.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0,
  parameter logic [ADDR_WIDTH-1:0] TRAP_VEC = ADDR_WIDTH'(32'h100)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   redirect_valid_i,
  input  logic [ADDR_WIDTH-1:0]  redirect_target_i,
  input  logic                   stall_i,
  output logic                   imem_req_o,
  output logic [ADDR_WIDTH-1:0]  imem_addr_o,
  input  logic                   imem_gnt_i,
  input  logic                   imem_rvalid_i,
  input  logic [INSTR_WIDTH-1:0] imem_rdata_i,
  output logic                   instr_valid_o,
  output logic [INSTR_WIDTH-1:0] instr_o,
  output logic [ADDR_WIDTH-1:0]  instr_pc_o,
  output logic                   trap_o
);

  fetch_state_t state_q, state_d;
  logic kill_q, kill_d;
  logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic [ADDR_WIDTH-1:0] instr_pc_q, instr_pc_d;
  logic pc_load;
  pc_sel_t pc_sel;
  logic [ADDR_WIDTH-1:0] pc, pc_next, target_aligned;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic trap_q, trap_d;
`endif

  assign target_aligned = redirect_target_i & ~ADDR_WIDTH'(3);

  fetch_pc_reg #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .RESET_PC  (RESET_PC),
    .TRAP_VEC  (TRAP_VEC)
  ) u_pc_reg (
    .clk      (clk),
    .rst      (rst),
    .load_en_i(pc_load),
    .sel_i    (pc_sel),
    .target_i (target_aligned),
    .pc_o     (pc),
    .pc_next_o(pc_next)
  );

  always_comb begin
    state_d    = state_q;
    kill_d     = kill_q;
    req_addr_d = req_addr_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    pc_load    = 1'b0;
    pc_sel     = PcTarget;
`ifdef FETCH_MISALIGN_TRAP_EN
    trap_d     = 1'b0;
`endif

    // A redirect always retargets the PC, whatever the state.
    if (redirect_valid_i) begin
      pc_load = 1'b1;
`ifdef FETCH_MISALIGN_TRAP_EN
      if (redirect_target_i[1:0] != 2'b00) begin
        pc_sel = PcTrap;
        trap_d = 1'b1;
      end
`endif
    end

    unique case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (redirect_valid_i) kill_d = 1'b1;
        if (imem_gnt_i) state_d = WAIT;
      end
      WAIT: begin
        if (redirect_valid_i) kill_d = 1'b1;
        if (imem_rvalid_i) begin
          if (kill_q || redirect_valid_i) begin
            kill_d  = 1'b0;
            state_d = REQ;
          end else begin
            instr_d    = imem_rdata_i;
            instr_pc_d = pc;
            state_d    = VALID;
          end
        end
      end
      VALID: begin
        if (redirect_valid_i) begin
          state_d = REQ;
        end else if (!stall_i) begin
          pc_load = 1'b1;
          pc_sel  = PcInc;
          state_d = REQ;
        end
      end
      default: state_d = IDLE;
    endcase

    // Request address is latched on entry to REQ so a mid-request redirect cannot move it.
    if (state_q != REQ && state_d == REQ) req_addr_d = pc_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      kill_q     <= 1'b0;
      req_addr_q <= '0;
      instr_q    <= '0;
      instr_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      kill_q     <= kill_d;
      req_addr_q <= req_addr_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  always_ff @(posedge clk) begin
    if (rst) trap_q <= 1'b0;
    else     trap_q <= trap_d;
  end
  assign trap_o = trap_q;
`else
  assign trap_o = 1'b0;
`endif

  assign imem_req_o    = (state_q == REQ);
  assign imem_addr_o   = req_addr_q;
  assign instr_valid_o = (state_q == VALID);
  assign instr_o       = instr_q;
  assign instr_pc_o    = instr_pc_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed table-driven bench for fetch_sequencer plus an 8-bit-address instance for wrap.
module tb_fetch_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        rv, stall, gnt, rvalid;
  logic [31:0] tgt, rdata;
  logic        req, iv, trap;
  logic [31:0] addr, instr, ipc;

  logic        req8, iv8, trap8;
  logic [7:0]  addr8, ipc8;
  logic [31:0] instr8;

  fetch_sequencer dut (
    .clk              (clk),
    .rst              (rst),
    .redirect_valid_i (rv),
    .redirect_target_i(tgt),
    .stall_i          (stall),
    .imem_req_o       (req),
    .imem_addr_o      (addr),
    .imem_gnt_i       (gnt),
    .imem_rvalid_i    (rvalid),
    .imem_rdata_i     (rdata),
    .instr_valid_o    (iv),
    .instr_o          (instr),
    .instr_pc_o       (ipc),
    .trap_o           (trap)
  );

  fetch_sequencer #(
    .ADDR_WIDTH(8),
    .RESET_PC  (8'hFC),
    .TRAP_VEC  (8'h00)
  ) dut8 (
    .clk              (clk),
    .rst              (rst),
    .redirect_valid_i (1'b0),
    .redirect_target_i(8'h00),
    .stall_i          (1'b0),
    .imem_req_o       (req8),
    .imem_addr_o      (addr8),
    .imem_gnt_i       (1'b1),
    .imem_rvalid_i    (1'b1),
    .imem_rdata_i     (32'h0000_0055),
    .instr_valid_o    (iv8),
    .instr_o          (instr8),
    .instr_pc_o       (ipc8),
    .trap_o           (trap8)
  );

`ifdef FETCH_MISALIGN_TRAP_EN
  localparam logic [31:0] MIS_ADDR = 32'h100;
  localparam logic        MIS_TRAP = 1'b1;
`else
  localparam logic [31:0] MIS_ADDR = 32'h300;
  localparam logic        MIS_TRAP = 1'b0;
`endif

  typedef struct {
    logic        rv;
    logic [31:0] tgt;
    logic        stall, gnt, rvalid;
    logic [31:0] rdata;
    logic        req;
    logic [31:0] addr;
    logic        iv;
    logic [31:0] instr, ipc;
    logic        trap;
  } vec_t;

  localparam int NVEC = 34;
  vec_t vecs [NVEC];

  int checks = 0;
  int failures = 0;

  function automatic vec_t mk(input logic r, input logic [31:0] t, input logic s, input logic g,
                              input logic v, input logic [31:0] d, input logic eq,
                              input logic [31:0] ea, input logic ev, input logic [31:0] ei,
                              input logic [31:0] ep, input logic et);
    vec_t x;
    x.rv = r; x.tgt = t; x.stall = s; x.gnt = g; x.rvalid = v; x.rdata = d;
    x.req = eq; x.addr = ea; x.iv = ev; x.instr = ei; x.ipc = ep; x.trap = et;
    return x;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] pack_main();
    return {25'd0, req, addr, iv, instr, ipc, trap};
  endfunction

  initial begin
    //                rv tgt        st g  v  rdata        req addr      iv instr     ipc       trap
    vecs[0]  = mk(0, 0,         0, 0, 0, 0,            0, 0,         0, 0,        0,        0);
    vecs[1]  = mk(0, 0,         0, 1, 0, 0,            1, 0,         0, 0,        0,        0);
    vecs[2]  = mk(0, 0,         0, 0, 1, 32'hA0,       0, 0,         0, 0,        0,        0);
    vecs[3]  = mk(0, 0,         0, 0, 0, 0,            0, 0,         1, 32'hA0,   0,        0);
    vecs[4]  = mk(0, 0,         0, 1, 1, 32'hFF,       1, 4,         0, 32'hA0,   0,        0);
    vecs[5]  = mk(0, 0,         0, 0, 1, 32'hA1,       0, 4,         0, 32'hA0,   0,        0);
    for (int k = 6; k <= 10; k++)
      vecs[k] = mk(0, 0,        1, 0, 0, 0,            0, 4,         1, 32'hA1,   4,        0);
    vecs[11] = mk(0, 0,         0, 0, 0, 0,            0, 4,         1, 32'hA1,   4,        0);
    vecs[12] = mk(0, 0,         0, 1, 0, 0,            1, 8,         0, 32'hA1,   4,        0);
    vecs[13] = mk(1, 32'h40,    0, 0, 0, 0,            0, 8,         0, 32'hA1,   4,        0);
    vecs[14] = mk(0, 0,         0, 0, 1, 32'hDEAD,     0, 8,         0, 32'hA1,   4,        0);
    vecs[15] = mk(0, 0,         0, 1, 0, 0,            1, 32'h40,    0, 32'hA1,   4,        0);
    vecs[16] = mk(0, 0,         0, 0, 1, 32'hA2,       0, 32'h40,    0, 32'hA1,   4,        0);
    vecs[17] = mk(1, 32'h100,   1, 0, 0, 0,            0, 32'h40,    1, 32'hA2,   32'h40,   0);
    for (int k = 18; k <= 20; k++)
      vecs[k] = mk(0, 0,        0, 0, 0, 0,            1, 32'h100,   0, 32'hA2,   32'h40,   0);
    vecs[21] = mk(0, 0,         0, 1, 0, 0,            1, 32'h100,   0, 32'hA2,   32'h40,   0);
    vecs[22] = mk(0, 0,         0, 0, 1, 32'hA3,       0, 32'h100,   0, 32'hA2,   32'h40,   0);
    vecs[23] = mk(0, 0,         0, 0, 0, 0,            0, 32'h100,   1, 32'hA3,   32'h100,  0);
    vecs[24] = mk(1, 32'h200,   0, 0, 0, 0,            1, 32'h104,   0, 32'hA3,   32'h100,  0);
    vecs[25] = mk(0, 0,         0, 1, 0, 0,            1, 32'h104,   0, 32'hA3,   32'h100,  0);
    vecs[26] = mk(0, 0,         0, 0, 1, 32'hBEEF,     0, 32'h104,   0, 32'hA3,   32'h100,  0);
    vecs[27] = mk(0, 0,         0, 1, 0, 0,            1, 32'h200,   0, 32'hA3,   32'h100,  0);
    vecs[28] = mk(0, 0,         0, 0, 0, 0,            0, 32'h200,   0, 32'hA3,   32'h100,  0);
    vecs[29] = mk(0, 0,         0, 0, 1, 32'hA4,       0, 32'h200,   0, 32'hA3,   32'h100,  0);
    vecs[30] = mk(1, 32'h303,   0, 0, 0, 0,            0, 32'h200,   1, 32'hA4,   32'h200,  0);
    vecs[31] = mk(0, 0,         0, 1, 0, 0,            1, MIS_ADDR,  0, 32'hA4,   32'h200,  MIS_TRAP);
    vecs[32] = mk(0, 0,         0, 0, 1, 32'hA5,       0, MIS_ADDR,  0, 32'hA4,   32'h200,  0);
    vecs[33] = mk(0, 0,         0, 0, 0, 0,            0, MIS_ADDR,  1, 32'hA5,   MIS_ADDR, 0);

    rv = 0; tgt = 0; stall = 0; gnt = 0; rvalid = 0; rdata = 0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", pack_main(), 128'd0);
    rst = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      rv = vecs[i].rv; tgt = vecs[i].tgt; stall = vecs[i].stall;
      gnt = vecs[i].gnt; rvalid = vecs[i].rvalid; rdata = vecs[i].rdata;
      chk($sformatf("row%0d", i), pack_main(),
          {25'd0, vecs[i].req, vecs[i].addr, vecs[i].iv, vecs[i].instr, vecs[i].ipc,
           vecs[i].trap});
      @(negedge clk);
    end

    // Mid-request reset, then a stale response arriving in IDLE must be ignored.
    rv = 0; stall = 0; rvalid = 0; gnt = 1;
    @(negedge clk);
    gnt = 0; rst = 1'b1;
    @(negedge clk);
    chk("midreset_main", pack_main(), 128'd0);
    chk("midreset_dut8", {87'd0, req8, addr8, iv8, instr8, ipc8}, 128'd0);
    rst = 1'b0; rvalid = 1; rdata = 32'h77;
    @(negedge clk);
    rvalid = 0;
    chk("post_reset_req", pack_main(), {25'd0, 1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0});
    chk("dut8_first_req", {119'd0, req8, addr8}, {119'd0, 1'b1, 8'hFC});
    @(negedge clk);
    @(negedge clk);
    chk("dut8_valid", {86'd0, iv8, instr8, ipc8, trap8}, {86'd0, 1'b1, 32'h55, 8'hFC, 1'b0});
    chk("stale_ignored", {96'd0, instr}, 128'd0);
    @(negedge clk);
    chk("dut8_wrap_req", {119'd0, req8, addr8}, {119'd0, 1'b1, 8'h00});
    chk("main_req_held", {95'd0, req, addr}, {95'd0, 1'b1, 32'h0});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
